// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // FETCH: request outstanding; HOLD: word buffered under stall;
    // DROP: response of a cancelled request still in flight.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential PC, wrapping modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program-counter register: loadable when enabled, async active-low reset.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    // Load the next PC only when the fetch logic advances or redirects.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_VAL;
        end else if (en_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding
// variable-latency request to instruction memory and feeds IF/ID with
// either the fetched word or a NOP bubble.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] instrF,
    output logic        instr_validF
);

    fetch_state_e state_q, state_d;
    logic [31:0]  hold_q, hold_d;
    logic [31:0]  drop_addr_q, drop_addr_d;
    logic [31:0]  pc_q, pc_d;
    logic         pc_en;
    logic         avail;

    pc_reg #(
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (pc_en),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    // An instruction is available when the memory answers this cycle or one is buffered.
    assign avail = reset &&
                   (((state_q == FETCH) && imem_rvalid) || (state_q == HOLD));

    // Next-state, PC and buffer updates in priority order: redirect, stall, advance, drain.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        drop_addr_d = drop_addr_q;
        pc_d        = pc_q;
        pc_en       = 1'b0;
        if (PCSrcD) begin
            pc_d  = PCBranchD;
            pc_en = 1'b1;
            case (state_q)
                FETCH: begin
                    if (!imem_rvalid) begin
                        // The in-flight request must still complete; remember its address.
                        state_d     = DROP;
                        drop_addr_d = pc_q;
                    end else begin
                        state_d = FETCH;
                    end
                end
                DROP: begin
                    // Only the target changes; the old response is still pending.
                    if (imem_rvalid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end else if (avail && stallF) begin
            state_d = HOLD;
            if (state_q == FETCH) begin
                hold_d = imem_rdata;
            end
        end else if (avail) begin
            pc_d    = pc_plus4(pc_q);
            pc_en   = 1'b1;
            state_d = FETCH;
        end else if ((state_q == DROP) && imem_rvalid) begin
            // Cancelled response discarded; PC already holds the redirect target.
            state_d = FETCH;
        end
    end

    // State and holding registers, cleared asynchronously with the memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            hold_q      <= NOP_INSTR;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    // Instruction presented to IF/ID: live response, buffered word, or bubble.
    always_comb begin
        instrF = NOP_INSTR;
        if (reset) begin
            case (state_q)
                FETCH:   instrF = imem_rvalid ? imem_rdata : NOP_INSTR;
                HOLD:    instrF = hold_q;
                default: instrF = NOP_INSTR;
            endcase
        end
    end

    assign instr_validF = avail;
    assign imem_req     = reset && (state_q != HOLD);
    assign imem_addr    = (state_q == DROP) ? drop_addr_q : pc_q;
    assign PCF          = pc_q;
    assign PCPlus4F     = pc_plus4(pc_q);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a variable-latency memory model and
// a scoreboard of expected instruction words.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stallF;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic [31:0] instrF;
    logic        instr_validF;

    // Second instance checks wrap-around from a high reset PC.
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_rvalid2;
    logic [31:0] imem_rdata2;
    logic [31:0] PCF2;
    logic [31:0] PCPlus4F2;
    logic [31:0] instrF2;
    logic        instr_validF2;

    int          lat;
    int          cnt;
    int          checks;
    int          errors;
    logic [31:0] sb[$];

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .stallF       (stallF),
        .PCSrcD       (PCSrcD),
        .PCBranchD    (PCBranchD),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .PCF          (PCF),
        .PCPlus4F     (PCPlus4F),
        .instrF       (instrF),
        .instr_validF (instr_validF)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .stallF       (1'b0),
        .PCSrcD       (1'b0),
        .PCBranchD    (32'h0),
        .imem_req     (imem_req2),
        .imem_addr    (imem_addr2),
        .imem_rvalid  (imem_rvalid2),
        .imem_rdata   (imem_rdata2),
        .PCF          (PCF2),
        .PCPlus4F     (PCPlus4F2),
        .instrF       (instrF2),
        .instr_validF (instr_validF2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: response after 'lat' extra cycles, data = address.
    assign imem_rvalid = imem_req && (cnt == lat);
    assign imem_rdata  = imem_rvalid ? imem_addr : 32'hDEAD_BEEF;

    always @(posedge clk or negedge reset) begin
        if (!reset) cnt <= 0;
        else if (imem_req && !imem_rvalid) cnt <= cnt + 1;
        else cnt <= 0;
    end

    // Zero-wait memory for the wrap-around instance.
    assign imem_rvalid2 = imem_req2;
    assign imem_rdata2  = imem_rvalid2 ? imem_addr2 : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare an instruction consumed by IF/ID against the scoreboard.
    task automatic sb_check();
        logic [31:0] e;
        if (reset && instr_validF && !stallF) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow: observed=%h expected=<none>", instrF);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_instr", instrF, e);
                chk("sb_pc", PCF, e);
            end
        end
    endtask

    task automatic adv();
        sb_check();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] wrap_exp [3];
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        stallF    = 1'b0;
        PCSrcD    = 1'b0;
        PCBranchD = 32'h0;
        lat       = 0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_pc", PCF, 32'h0);
        chk("rst_pc4", PCPlus4F, 32'h4);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_instr", instrF, 32'h0);
        chk("rst_valid", {31'b0, instr_validF}, 32'h0);
        chk("rst_pc_hi", PCF2, 32'hFFFF_FFF8);
        chk("rst_pc4_hi", PCPlus4F2, 32'hFFFF_FFFC);

        // Zero-wait memory: one instruction per cycle, plus wrap-around instance
        reset = 1'b1;
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        sb.push_back(32'h8);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("zw_req", {31'b0, imem_req}, 32'h1);
            chk("zw_pc", PCF, 32'(4 * k));
            chk("zw_pc4", PCPlus4F, 32'(4 * k + 4));
            chk("zw_valid", {31'b0, instr_validF}, 32'h1);
            chk("wrap_pc", PCF2, wrap_exp[k]);
            chk("wrap_pc4", PCPlus4F2, wrap_exp[k] + 32'd4);
            chk("wrap_instr", instrF2, wrap_exp[k]);
            adv();
        end

        // 3-cycle latency: two bubbles before each instruction
        lat = 2;
        sb.push_back(32'hC);
        sb.push_back(32'h10);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 3; j++) begin
                #1;
                chk("lat_addr", imem_addr, 32'(12 + 4 * i));
                chk("lat_req", {31'b0, imem_req}, 32'h1);
                if (j < 2) begin
                    chk("lat_bubble", instrF, 32'h0);
                    chk("lat_bubble_v", {31'b0, instr_validF}, 32'h0);
                end
                adv();
            end
        end

        // Asynchronous reset in the middle of a wait
        #1;
        chk("mid_addr", imem_addr, 32'h14);
        adv();
        #1;
        chk("mid_req", {31'b0, imem_req}, 32'h1);
        reset = 1'b0;
        #1;
        chk("arst_pc", PCF, 32'h0);
        chk("arst_pc4", PCPlus4F, 32'h4);
        chk("arst_req", {31'b0, imem_req}, 32'h0);
        chk("arst_valid", {31'b0, instr_validF}, 32'h0);
        chk("arst_pc_hi", PCF2, 32'hFFFF_FFF8);
        adv();
        reset = 1'b1;
        #1;
        chk("rel_req", {31'b0, imem_req}, 32'h1);
        chk("rel_addr", imem_addr, 32'h0);
        sb.push_back(32'h0);
        adv();
        #1;
        adv();
        #1;
        adv();

        // Stall for three cycles when the word for PC 8 arrives
        lat = 0;
        sb.push_back(32'h4);
        #1;
        adv();
        stallF = 1'b1;
        sb.push_back(32'h8);
        #1;
        chk("st_instr0", instrF, 32'h8);
        chk("st_valid0", {31'b0, instr_validF}, 32'h1);
        chk("st_req0", {31'b0, imem_req}, 32'h1);
        chk("st_pc0", PCF, 32'h8);
        adv();
        for (int s = 0; s < 2; s++) begin
            #1;
            chk("st_hold_req", {31'b0, imem_req}, 32'h0);
            chk("st_hold_instr", instrF, 32'h8);
            chk("st_hold_valid", {31'b0, instr_validF}, 32'h1);
            chk("st_hold_pc", PCF, 32'h8);
            adv();
        end
        stallF = 1'b0;
        #1;
        chk("st_rel_req", {31'b0, imem_req}, 32'h0);
        adv();
        sb.push_back(32'hC);
        #1;
        chk("st_next_addr", imem_addr, 32'hC);
        chk("st_next_req", {31'b0, imem_req}, 32'h1);
        adv();

        // Redirect to 0x40 while a 3-cycle request to 0x10 is pending
        lat       = 2;
        PCSrcD    = 1'b1;
        PCBranchD = 32'h40;
        #1;
        chk("br_addr0", imem_addr, 32'h10);
        chk("br_instr0", instrF, 32'h0);
        chk("br_valid0", {31'b0, instr_validF}, 32'h0);
        adv();
        PCSrcD    = 1'b0;
        PCBranchD = 32'h0;
        #1;
        chk("br_pc1", PCF, 32'h40);
        chk("br_addr1", imem_addr, 32'h10);
        chk("br_req1", {31'b0, imem_req}, 32'h1);
        chk("br_valid1", {31'b0, instr_validF}, 32'h0);
        adv();
        #1;
        chk("br_drop_addr", imem_addr, 32'h10);
        chk("br_drop_instr", instrF, 32'h0);
        chk("br_drop_valid", {31'b0, instr_validF}, 32'h0);
        adv();
        sb.push_back(32'h40);
        #1;
        chk("br_new_addr", imem_addr, 32'h40);
        chk("br_new_req", {31'b0, imem_req}, 32'h1);
        chk("br_new_pc", PCF, 32'h40);
        adv();
        adv();
        adv();

        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
